// File: rtl/tube_display_arbiter.sv
// Arbitrates the 8-digit seven-segment display between three requesters and scans the owner's
// digits onto two 4-digit banks. Optional digit blinking is built when DISP_BLINK_EN is defined.
module tube_display_arbiter #(
    parameter int unsigned SCAN_DIV    = 100000,
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [31:0] disp_data0,
    input  logic [31:0] disp_data1,
    input  logic [31:0] disp_data2,
    input  logic [7:0]  disp_blank0,
    input  logic [7:0]  disp_blank1,
    input  logic [7:0]  disp_blank2,
    input  logic [7:0]  disp_dp0,
    input  logic [7:0]  disp_dp1,
    input  logic [7:0]  disp_dp2,
    input  logic [7:0]  blink_mask,
    output logic [2:0]  grant,
    output logic        busy,
    output logic [7:0]  tube_switch,
    output logic [7:0]  tube_character_left,
    output logic [7:0]  tube_character_right
);

    localparam int unsigned SW = $clog2(SCAN_DIV + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [SW-1:0] DIV_LAST = SW'(SCAN_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    typedef enum logic {StIdle, StOwn} state_e;

    state_e        state;
    logic [HW-1:0] hold_cnt;
    logic [SW-1:0] div_cnt;
    logic [1:0]    slot;
    logic [2:0]    higher;
    logic [7:0]    blink_off;

    function automatic logic [2:0] top_one(input logic [2:0] r);
        if (r[2]) return 3'b100;
        if (r[1]) return 3'b010;
        if (r[0]) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [7:0] hex_seg(input logic [3:0] h);
        logic [7:0] s;
        unique case (h)
            4'h0: s = 8'hFC;
            4'h1: s = 8'h60;
            4'h2: s = 8'hDA;
            4'h3: s = 8'hF2;
            4'h4: s = 8'h66;
            4'h5: s = 8'hB6;
            4'h6: s = 8'hBE;
            4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;
            4'h9: s = 8'hF6;
            4'hA: s = 8'hEE;
            4'hB: s = 8'h3E;
            4'hC: s = 8'h9C;
            4'hD: s = 8'h7A;
            4'hE: s = 8'h9E;
            4'hF: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Requesters that outrank the current owner and may preempt it.
    always_comb begin
        higher = 3'b000;
        case (grant)
            3'b001:  higher = 3'b110;
            3'b010:  higher = 3'b100;
            default: higher = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            grant    <= 3'b000;
            hold_cnt <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (|req) begin
                        grant    <= top_one(req);
                        state    <= StOwn;
                        hold_cnt <= '0;
                    end
                end
                StOwn: begin
                    if (~|(req & grant)) begin
                        // Owner released: hand straight over, hold time does not apply.
                        grant    <= top_one(req);
                        hold_cnt <= '0;
                        if (~|req) state <= StIdle;
                    end else if ((|(req & higher)) && (hold_cnt == HOLD_MAX)) begin
                        grant    <= top_one(req & higher);
                        hold_cnt <= '0;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state    <= StIdle;
                    grant    <= 3'b000;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    assign busy = |grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            slot    <= 2'd0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            slot    <= slot + 2'd1;
        end else begin
            div_cnt <= div_cnt + SW'(1);
        end
    end

`ifdef DISP_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign blink_off = blink_phase ? blink_mask : 8'h00;
`else
    logic unused_blink;
    assign unused_blink = ^{blink_mask, BLINK_DIV[0]};
    assign blink_off    = 8'h00;
`endif

    logic [31:0] sel_data;
    logic [7:0]  sel_blank;
    logic [7:0]  sel_dp;
    logic [2:0]  left_idx;
    logic [2:0]  right_idx;
    logic [7:0]  left_seg;
    logic [7:0]  right_seg;

    always_comb begin
        sel_data  = 32'h0;
        sel_blank = 8'h00;
        sel_dp    = 8'h00;
        case (grant)
            3'b001:  begin sel_data = disp_data0; sel_blank = disp_blank0; sel_dp = disp_dp0; end
            3'b010:  begin sel_data = disp_data1; sel_blank = disp_blank1; sel_dp = disp_dp1; end
            3'b100:  begin sel_data = disp_data2; sel_blank = disp_blank2; sel_dp = disp_dp2; end
            default: begin sel_data = 32'h0; sel_blank = 8'h00; sel_dp = 8'h00; end
        endcase
    end

    // 7-s and 3-s for a 2-bit slot are just the inverted slot with the bank bit on top.
    assign left_idx  = {1'b1, ~slot};
    assign right_idx = {1'b0, ~slot};

    always_comb begin
        left_seg  = hex_seg(sel_data[{left_idx, 2'b00} +: 4]) | {7'b0, sel_dp[left_idx]};
        right_seg = hex_seg(sel_data[{right_idx, 2'b00} +: 4]) | {7'b0, sel_dp[right_idx]};
        if (sel_blank[left_idx] || blink_off[left_idx]) left_seg = 8'h00;
        if (sel_blank[right_idx] || blink_off[right_idx]) right_seg = 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tube_switch          <= 8'h00;
            tube_character_left  <= 8'h00;
            tube_character_right <= 8'h00;
        end else if (grant == 3'b000) begin
            tube_switch          <= 8'h00;
            tube_character_left  <= 8'h00;
            tube_character_right <= 8'h00;
        end else begin
            tube_switch          <= (8'h80 >> slot) | (8'h08 >> slot);
            tube_character_left  <= left_seg;
            tube_character_right <= right_seg;
        end
    end

endmodule
